// File: rtl/alu_issue_stage.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

// ============================================================================
// Module      : alu_issue_stage
// Description : ID/EX pipeline register feeding the ALU. Holds one decoded
//               instruction, forwards MEM/WB results into its source operands,
//               selects PC/immediate operands, stalls on load-use hazards and
//               drops work on a branch-redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int N     = `XLEN,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  // decode side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [N-1:0]     in_rs1_val,
  input  logic [N-1:0]     in_rs2_val,
  input  logic [N-1:0]     in_imm,
  input  logic [N-1:0]     in_pc,
  input  logic             in_a_sel_pc,
  input  logic             in_b_sel_imm,
  input  logic [3:0]       in_alu_control,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_is_load,
  // forwarding sources
  input  logic             mem_wr_en,
  input  logic             mem_is_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [N-1:0]     mem_result,
  input  logic             wb_wr_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [N-1:0]     wb_result,
  // execute side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_control,
  output logic [REG_W-1:0] out_rd,
  output logic             out_is_load,
  output logic [N-1:0]     out_rs2_fwd
);

  localparam logic [REG_W-1:0] c_x0 = '0;

  logic             valid_q;
  logic [REG_W-1:0] rs1_q;
  logic [REG_W-1:0] rs2_q;
  logic [N-1:0]     rs1_val_q;
  logic [N-1:0]     rs2_val_q;
  logic [N-1:0]     imm_q;
  logic [N-1:0]     pc_q;
  logic             a_sel_pc_q;
  logic             b_sel_imm_q;
  logic [3:0]       alu_control_q;
  logic [REG_W-1:0] rd_q;
  logic             is_load_q;

  logic             hazard;
  logic             capture;
  logic             rs1_load_match;
  logic             rs2_load_match;
  logic             wb_hit_rs1;
  logic             wb_hit_rs2;
  logic [N-1:0]     fwd_rs1;
  logic [N-1:0]     fwd_rs2;

  // Load-use detection: a MEM load whose data is not yet available; rs1 only
  // matters when it actually feeds operand a, rs2 always (it is store data).
  always_comb begin
    rs1_load_match = (rs1_q != c_x0) && (rs1_q == mem_rd) && !a_sel_pc_q;
    rs2_load_match = (rs2_q != c_x0) && (rs2_q == mem_rd);
    hazard         = valid_q && mem_wr_en && mem_is_load && (rs1_load_match || rs2_load_match);
    out_valid      = valid_q && !hazard;
    in_ready       = !valid_q || (out_valid && out_ready);
    capture        = in_valid && in_ready && !flush;
    wb_hit_rs1     = wb_wr_en && (rs1_q != c_x0) && (wb_rd == rs1_q);
    wb_hit_rs2     = wb_wr_en && (rs2_q != c_x0) && (wb_rd == rs2_q);
  end

  // rs1 forwarding: x0 is hard zero, MEM (non-load) beats WB, else held value
  always_comb begin
    fwd_rs1 = rs1_val_q;
    if (rs1_q == c_x0) begin
      fwd_rs1 = '0;
    end else if (mem_wr_en && !mem_is_load && (mem_rd == rs1_q)) begin
      fwd_rs1 = mem_result;
    end else if (wb_hit_rs1) begin
      fwd_rs1 = wb_result;
    end
  end

  // rs2 forwarding: same priority as rs1
  always_comb begin
    fwd_rs2 = rs2_val_q;
    if (rs2_q == c_x0) begin
      fwd_rs2 = '0;
    end else if (mem_wr_en && !mem_is_load && (mem_rd == rs2_q)) begin
      fwd_rs2 = mem_result;
    end else if (wb_hit_rs2) begin
      fwd_rs2 = wb_result;
    end
  end

  // Operand muxing into the ALU and pass-through of held fields
  always_comb begin
    alu_a       = a_sel_pc_q  ? pc_q  : fwd_rs1;
    alu_b       = b_sel_imm_q ? imm_q : fwd_rs2;
    alu_control = alu_control_q;
    out_rd      = rd_q;
    out_is_load = is_load_q;
    out_rs2_fwd = fwd_rs2;
  end

  // Valid tracking: flush wins, then capture, then consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
    end else if (out_valid && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Held instruction fields: load on capture, otherwise refresh register
  // values from WB so a stalled instruction survives its producer retiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q         <= '0;
      rs2_q         <= '0;
      rs1_val_q     <= '0;
      rs2_val_q     <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      a_sel_pc_q    <= 1'b0;
      b_sel_imm_q   <= 1'b0;
      alu_control_q <= 4'd0;
      rd_q          <= '0;
      is_load_q     <= 1'b0;
    end else if (capture) begin
      rs1_q         <= in_rs1;
      rs2_q         <= in_rs2;
      rs1_val_q     <= in_rs1_val;
      rs2_val_q     <= in_rs2_val;
      imm_q         <= in_imm;
      pc_q          <= in_pc;
      a_sel_pc_q    <= in_a_sel_pc;
      b_sel_imm_q   <= in_b_sel_imm;
      alu_control_q <= in_alu_control;
      rd_q          <= in_rd;
      is_load_q     <= in_is_load;
    end else if (valid_q) begin
      if (wb_hit_rs1) begin
        rs1_val_q <= wb_result;
      end
      if (wb_hit_rs2) begin
        rs2_val_q <= wb_result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none

// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed-vector bench for alu_issue_stage with hand-computed
//               expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  localparam int N     = 32;
  localparam int REG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [REG_W-1:0] in_rs1;
  logic [REG_W-1:0] in_rs2;
  logic [N-1:0]     in_rs1_val;
  logic [N-1:0]     in_rs2_val;
  logic [N-1:0]     in_imm;
  logic [N-1:0]     in_pc;
  logic             in_a_sel_pc;
  logic             in_b_sel_imm;
  logic [3:0]       in_alu_control;
  logic [REG_W-1:0] in_rd;
  logic             in_is_load;
  logic             mem_wr_en;
  logic             mem_is_load;
  logic [REG_W-1:0] mem_rd;
  logic [N-1:0]     mem_result;
  logic             wb_wr_en;
  logic [REG_W-1:0] wb_rd;
  logic [N-1:0]     wb_result;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [3:0]       alu_control;
  logic [REG_W-1:0] out_rd;
  logic             out_is_load;
  logic [N-1:0]     out_rs2_fwd;

  int vectors_applied = 0;
  int miscompares     = 0;

  alu_issue_stage #(.N(N), .REG_W(REG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rs1_val     (in_rs1_val),
    .in_rs2_val     (in_rs2_val),
    .in_imm         (in_imm),
    .in_pc          (in_pc),
    .in_a_sel_pc    (in_a_sel_pc),
    .in_b_sel_imm   (in_b_sel_imm),
    .in_alu_control (in_alu_control),
    .in_rd          (in_rd),
    .in_is_load     (in_is_load),
    .mem_wr_en      (mem_wr_en),
    .mem_is_load    (mem_is_load),
    .mem_rd         (mem_rd),
    .mem_result     (mem_result),
    .wb_wr_en       (wb_wr_en),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_control    (alu_control),
    .out_rd         (out_rd),
    .out_is_load    (out_is_load),
    .out_rs2_fwd    (out_rs2_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge; inputs changed afterwards are clear of the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [REG_W-1:0] rs1, input logic [N-1:0] v1,
                       input logic [REG_W-1:0] rs2, input logic [N-1:0] v2,
                       input logic a_pc, input logic [N-1:0] pc,
                       input logic b_imm, input logic [N-1:0] imm,
                       input logic [3:0] ctrl, input logic [REG_W-1:0] rd);
    in_valid       = 1'b1;
    in_rs1         = rs1;
    in_rs1_val     = v1;
    in_rs2         = rs2;
    in_rs2_val     = v2;
    in_a_sel_pc    = a_pc;
    in_pc          = pc;
    in_b_sel_imm   = b_imm;
    in_imm         = imm;
    in_alu_control = ctrl;
    in_rd          = rd;
    in_is_load     = 1'b0;
  endtask

  task automatic clear_fwd();
    mem_wr_en   = 1'b0;
    mem_is_load = 1'b0;
    mem_rd      = '0;
    mem_result  = '0;
    wb_wr_en    = 1'b0;
    wb_rd       = '0;
    wb_result   = '0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    offer('0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 4'd0, '0);
    in_valid = 1'b0;
    clear_fwd();

    // Reset state
    #2;
    check_vec("rst_out_valid", 64'(out_valid), 64'd0);
    check_vec("rst_alu_a", 64'(alu_a), 64'd0);
    check_vec("rst_alu_b", 64'(alu_b), 64'd0);
    check_vec("rst_ctrl", 64'(alu_control), 64'd0);
    check_vec("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;
    tick();

    // T1: plain ADD from register reads
    out_ready = 1'b1;
    offer(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    #1;
    check_vec("t1_out_valid", 64'(out_valid), 64'd1);
    check_vec("t1_alu_a", 64'(alu_a), 64'd5);
    check_vec("t1_alu_b", 64'(alu_b), 64'd7);
    check_vec("t1_ctrl", 64'(alu_control), 64'd0);
    check_vec("t1_out_rd", 64'(out_rd), 64'd3);
    tick();
    check_vec("t1_consumed", 64'(out_valid), 64'd0);

    // T2: MEM beats WB on rs1, then WB alone, then refreshed held value
    out_ready = 1'b0;
    offer(5'd3, 32'h1, 5'd0, 32'h5, 1'b0, 32'h0, 1'b1, 32'h44, 4'd5, 5'd7);
    tick();
    in_valid = 1'b0;
    mem_wr_en = 1'b1; mem_rd = 5'd3; mem_result = 32'h10;
    wb_wr_en = 1'b1; wb_rd = 5'd3; wb_result = 32'h20;
    #1;
    check_vec("t2_mem_prio", 64'(alu_a), 64'h10);
    check_vec("t2_alu_b_imm", 64'(alu_b), 64'h44);
    check_vec("t2_ctrl", 64'(alu_control), 64'd5);
    check_vec("t2_rs2_x0", 64'(out_rs2_fwd), 64'd0);
    mem_wr_en = 1'b0;
    #1;
    check_vec("t2_wb_fwd", 64'(alu_a), 64'h20);
    tick();
    clear_fwd();
    #1;
    check_vec("t2_refresh", 64'(alu_a), 64'h20);
    out_ready = 1'b1;
    tick();
    check_vec("t2_consumed", 64'(out_valid), 64'd0);

    // T3: x0 never forwarded, and a load to x0 is no hazard
    offer(5'd0, 32'h55, 5'd0, 32'h66, 1'b0, 32'h0, 1'b0, 32'h0, 4'd1, 5'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    mem_wr_en = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
    #1;
    check_vec("t3_x0_a", 64'(alu_a), 64'd0);
    mem_is_load = 1'b1;
    #1;
    check_vec("t3_x0_nohaz", 64'(out_valid), 64'd1);
    clear_fwd();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // T4: load-use on rs2, resolved by WB; rs1 ignored since a = PC
    offer(5'd9, 32'h3, 5'd4, 32'h11, 1'b1, 32'h1000, 1'b0, 32'h0, 4'd0, 5'd8);
    tick();
    in_valid = 1'b0;
    mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd4;
    #1;
    check_vec("t4_haz_valid", 64'(out_valid), 64'd0);
    check_vec("t4_haz_ready", 64'(in_ready), 64'd0);
    mem_rd = 5'd9;
    #1;
    check_vec("t4_rs1_unused", 64'(out_valid), 64'd1);
    mem_rd = 5'd4;
    tick();
    clear_fwd();
    wb_wr_en = 1'b1; wb_rd = 5'd4; wb_result = 32'h99;
    #1;
    check_vec("t4_wb_valid", 64'(out_valid), 64'd1);
    check_vec("t4_wb_b", 64'(alu_b), 64'h99);
    check_vec("t4_pc_a", 64'(alu_a), 64'h1000);
    check_vec("t4_store_fwd", 64'(out_rs2_fwd), 64'h99);
    tick();
    clear_fwd();
    #1;
    check_vec("t4_held_b", 64'(alu_b), 64'h99);

    // T5: backpressure holds the instruction for three cycles
    offer(5'd1, 32'hA, 5'd2, 32'hB, 1'b0, 32'h0, 1'b0, 32'h0, 4'd3, 5'd12);
    #1;
    check_vec("t5_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("t5_hold_b", 64'(alu_b), 64'h99);
      check_vec("t5_hold_rd", 64'(out_rd), 64'd8);
      check_vec("t5_hold_valid", 64'(out_valid), 64'd1);
    end

    // T6: flush drops held and incoming
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_vec("t6_flush_valid", 64'(out_valid), 64'd0);
    check_vec("t6_flush_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset while stalled on a load-use hazard
    out_ready = 1'b0;
    offer(5'd2, 32'h77, 5'd4, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0, 4'd2, 5'd6);
    tick();
    in_valid = 1'b0;
    #1;
    check_vec("t6_pre_a", 64'(alu_a), 64'h77);
    mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd4;
    #1;
    check_vec("t6_stall", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check_vec("t6_rst_valid", 64'(out_valid), 64'd0);
    check_vec("t6_rst_a", 64'(alu_a), 64'd0);
    check_vec("t6_rst_ctrl", 64'(alu_control), 64'd0);
    check_vec("t6_rst_ready", 64'(in_ready), 64'd1);
    clear_fwd();
    rst_n = 1'b1;
    tick();
    check_vec("t6_post_rst", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
